mismatch_scoreboard: RTL and testbench

Synthesizable result checker that sits directly downstream of the reference model and the device under test. It consumes their paired outputs (`f_ref`, `f_dut`) one sample at a time and keeps in-hardware statistics: samples checked, mismatches, index of the first mismatch, and an end-of-run flag. This replaces the simulation-only counting in the bench, so checks can run on an emulator or FPGA.

---
 rtl/mismatch_scoreboard_if.sv | 32 +++
 rtl/mismatch_scoreboard.sv | 151 +++++++++++++++
 tb/tb_mismatch_scoreboard.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mismatch_scoreboard_if.sv
// ---------------------------------------------------------------------------
// mismatch_scoreboard_if
// Sample stream into the scoreboard: a run-control pulse plus the paired
// reference/DUT output vectors.
//   start        : single-cycle pulse, clears statistics and begins a run
//   sample_valid : f_ref/f_dut carry a sample to check this cycle
//   f_ref        : reference model output (W bits)
//   f_dut        : device-under-test output (W bits)
// master = sample producer, slave = scoreboard.
// ---------------------------------------------------------------------------
interface mismatch_scoreboard_if #(
    parameter int W = 1
) ();
    logic         start;
    logic         sample_valid;
    logic [W-1:0] f_ref;
    logic [W-1:0] f_dut;

    modport master (
        output start,
        output sample_valid,
        output f_ref,
        output f_dut
    );

    modport slave (
        input start,
        input sample_valid,
        input f_ref,
        input f_dut
    );
endinterface

// File: rtl/mismatch_scoreboard.sv
// ---------------------------------------------------------------------------
// mismatch_scoreboard
// Hardware result checker: compares reference and DUT outputs sample by
// sample and keeps run statistics that can be read on an emulator/FPGA.
//
// Ports:
//   clk_i            : clock, rising edge
//   areset_n_i       : asynchronous active-low reset
//   sb_if (slave)    : start / sample_valid / f_ref / f_dut
//   running_o        : run in progress
//   done_o           : run finished, statistics frozen
//   mismatch_o       : compare result of the last accepted sample
//   sample_cnt_o     : accepted samples this run (saturating)
//   error_cnt_o      : mismatching samples this run (saturating)
//   first_err_vld_o  : a mismatch has been seen this run
//   first_err_idx_o  : 0-based index of the first mismatching sample
//   err_mask_o       : OR of all mismatching bit positions
//
// Build option: define MISMATCH_SCOREBOARD_MASK_EN to implement the error
// mask register; otherwise err_mask_o is constant zero.
//
// state | meaning
// IDLE  | after reset, samples ignored until start
// RUN   | samples accepted and checked
// DONE  | NUM_SAMPLES reached, outputs frozen until start
// ---------------------------------------------------------------------------
module mismatch_scoreboard #(
    parameter int          W           = 1,
    parameter int          CW          = 16,
    parameter int unsigned NUM_SAMPLES = 100
) (
    input  logic                 clk_i,
    input  logic                 areset_n_i,
    mismatch_scoreboard_if.slave sb_if,
    output logic                 running_o,
    output logic                 done_o,
    output logic                 mismatch_o,
    output logic [CW-1:0]        sample_cnt_o,
    output logic [CW-1:0]        error_cnt_o,
    output logic                 first_err_vld_o,
    output logic [CW-1:0]        first_err_idx_o,
    output logic [W-1:0]         err_mask_o
);

    // One bit per active state so running/done come straight off flops.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] NUM_CW  = CW'(NUM_SAMPLES);
    // A run length the counter can never reach behaves like an unbounded run.
    localparam bit DONE_EN = (NUM_SAMPLES != 0) && ((NUM_SAMPLES >> CW) == 0);

    logic [1:0]    state_q, state_d;
    logic          mismatch_q, mismatch_d;
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic [CW-1:0] error_cnt_q, error_cnt_d;
    logic          first_err_vld_q, first_err_vld_d;
    logic [CW-1:0] first_err_idx_q, first_err_idx_d;

    logic mism;
    logic accept;

    assign mism   = (sb_if.f_ref != sb_if.f_dut);
    // start takes priority: a sample arriving with start is dropped.
    assign accept = !sb_if.start && sb_if.sample_valid && (state_q == ST_RUN);

    always_comb begin
        state_d         = state_q;
        mismatch_d      = mismatch_q;
        sample_cnt_d    = sample_cnt_q;
        error_cnt_d     = error_cnt_q;
        first_err_vld_d = first_err_vld_q;
        first_err_idx_d = first_err_idx_q;

        if (sb_if.start) begin
            state_d         = ST_RUN;
            mismatch_d      = 1'b0;
            sample_cnt_d    = '0;
            error_cnt_d     = '0;
            first_err_vld_d = 1'b0;
            first_err_idx_d = '0;
        end else if (accept) begin
            mismatch_d   = mism;
            sample_cnt_d = (sample_cnt_q == CNT_MAX) ? sample_cnt_q : sample_cnt_q + 1'b1;
            if (mism) begin
                error_cnt_d = (error_cnt_q == CNT_MAX) ? error_cnt_q : error_cnt_q + 1'b1;
                if (!first_err_vld_q) begin
                    first_err_vld_d = 1'b1;
                    first_err_idx_d = sample_cnt_q;
                end
            end
            if (DONE_EN && (sample_cnt_d == NUM_CW)) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge areset_n_i) begin
        if (!areset_n_i) begin
            state_q         <= ST_IDLE;
            mismatch_q      <= 1'b0;
            sample_cnt_q    <= '0;
            error_cnt_q     <= '0;
            first_err_vld_q <= 1'b0;
            first_err_idx_q <= '0;
        end else begin
            state_q         <= state_d;
            mismatch_q      <= mismatch_d;
            sample_cnt_q    <= sample_cnt_d;
            error_cnt_q     <= error_cnt_d;
            first_err_vld_q <= first_err_vld_d;
            first_err_idx_q <= first_err_idx_d;
        end
    end

`ifdef MISMATCH_SCOREBOARD_MASK_EN
    logic [W-1:0] err_mask_q, err_mask_d;

    always_comb begin
        err_mask_d = err_mask_q;
        if (sb_if.start) begin
            err_mask_d = '0;
        end else if (accept) begin
            err_mask_d = err_mask_q | (sb_if.f_ref ^ sb_if.f_dut);
        end
    end

    always_ff @(posedge clk_i or negedge areset_n_i) begin
        if (!areset_n_i) begin
            err_mask_q <= '0;
        end else begin
            err_mask_q <= err_mask_d;
        end
    end

    assign err_mask_o = err_mask_q;
`else
    assign err_mask_o = '0;
`endif

    assign running_o       = state_q[0];
    assign done_o          = state_q[1];
    assign mismatch_o      = mismatch_q;
    assign sample_cnt_o    = sample_cnt_q;
    assign error_cnt_o     = error_cnt_q;
    assign first_err_vld_o = first_err_vld_q;
    assign first_err_idx_o = first_err_idx_q;

endmodule

// File: tb/tb_mismatch_scoreboard.sv
module tb_mismatch_scoreboard;

`ifdef MISMATCH_SCOREBOARD_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic clk;
    logic areset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: W=4, CW=16, NUM_SAMPLES=100
    mismatch_scoreboard_if #(.W(4)) ifa ();
    logic        a_running, a_done, a_mism, a_fvld;
    logic [15:0] a_scnt, a_ecnt, a_fidx;
    logic [3:0]  a_mask;

    mismatch_scoreboard #(.W(4), .CW(16), .NUM_SAMPLES(100)) dut_a (
        .clk_i           (clk),
        .areset_n_i      (areset_n),
        .sb_if           (ifa.slave),
        .running_o       (a_running),
        .done_o          (a_done),
        .mismatch_o      (a_mism),
        .sample_cnt_o    (a_scnt),
        .error_cnt_o     (a_ecnt),
        .first_err_vld_o (a_fvld),
        .first_err_idx_o (a_fidx),
        .err_mask_o      (a_mask)
    );

    // Instance B: W=1, CW=4, unbounded run (saturation)
    mismatch_scoreboard_if #(.W(1)) ifb ();
    logic       b_running, b_done, b_mism, b_fvld;
    logic [3:0] b_scnt, b_ecnt, b_fidx;
    logic [0:0] b_mask;

    mismatch_scoreboard #(.W(1), .CW(4), .NUM_SAMPLES(0)) dut_b (
        .clk_i           (clk),
        .areset_n_i      (areset_n),
        .sb_if           (ifb.slave),
        .running_o       (b_running),
        .done_o          (b_done),
        .mismatch_o      (b_mism),
        .sample_cnt_o    (b_scnt),
        .error_cnt_o     (b_ecnt),
        .first_err_vld_o (b_fvld),
        .first_err_idx_o (b_fidx),
        .err_mask_o      (b_mask)
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic       st;
        logic       v;
        logic [3:0] r;
        logic [3:0] d;
        logic       run;
        logic       done;
        logic       mism;
        int         scnt;
        int         ecnt;
        logic       fvld;
        int         fidx;
        logic [3:0] mask;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic run, input logic done, input logic mism,
                           input int scnt, input int ecnt, input logic fvld, input int fidx,
                           input logic [3:0] mask);
        check({tag, ".running"},  32'(a_running), 32'(run));
        check({tag, ".done"},     32'(a_done),    32'(done));
        check({tag, ".mismatch"}, 32'(a_mism),    32'(mism));
        check({tag, ".scnt"},     32'(a_scnt),    scnt);
        check({tag, ".ecnt"},     32'(a_ecnt),    ecnt);
        check({tag, ".fvld"},     32'(a_fvld),    32'(fvld));
        check({tag, ".fidx"},     32'(a_fidx),    fidx);
        check({tag, ".mask"},     32'(a_mask),    MASK_EN ? 32'(mask) : 32'd0);
    endtask

    task automatic drive_a(input logic st, input logic v, input logic [3:0] r, input logic [3:0] d);
        ifa.start        = st;
        ifa.sample_valid = v;
        ifa.f_ref        = r;
        ifa.f_dut        = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             st    v     r     d     run   done  mism  scnt ecnt fvld  fidx mask
        vecs[0]  = '{1'b0, 1'b1, 4'h3, 4'h5, 1'b0, 1'b0, 1'b0, 0,   0,   1'b0, 0,   4'h0};
        vecs[1]  = '{1'b0, 1'b1, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 0,   0,   1'b0, 0,   4'h0};
        vecs[2]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 0,   0,   1'b0, 0,   4'h0};
        vecs[3]  = '{1'b0, 1'b1, 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 1,   0,   1'b0, 0,   4'h0};
        vecs[4]  = '{1'b0, 1'b1, 4'h1, 4'h3, 1'b1, 1'b0, 1'b1, 2,   1,   1'b1, 1,   4'h2};
        vecs[5]  = '{1'b0, 1'b0, 4'h7, 4'h0, 1'b1, 1'b0, 1'b1, 2,   1,   1'b1, 1,   4'h2};
        vecs[6]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 3,   1,   1'b1, 1,   4'h2};
        vecs[7]  = '{1'b0, 1'b1, 4'h8, 4'h0, 1'b1, 1'b0, 1'b1, 4,   2,   1'b1, 1,   4'hA};
        vecs[8]  = '{1'b1, 1'b1, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 0,   0,   1'b0, 0,   4'h0};
        vecs[9]  = '{1'b0, 1'b1, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1,   0,   1'b0, 0,   4'h0};
        vecs[10] = '{1'b0, 1'b1, 4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 2,   1,   1'b1, 1,   4'h4};
        vecs[11] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 0,   0,   1'b0, 0,   4'h0};
        vecs[12] = '{1'b0, 1'b1, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 1,   1,   1'b1, 0,   4'h1};
        vecs[13] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2,   2,   1'b1, 0,   4'hF};

        drive_a(1'b0, 1'b0, 4'h0, 4'h0);
        ifb.start = 1'b0; ifb.sample_valid = 1'b0; ifb.f_ref = 1'b0; ifb.f_dut = 1'b0;

        areset_n = 1'b0;
        #12 areset_n = 1'b1;
        tick();
        check_a("reset", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 4'h0);
        check("reset_b.running", 32'(b_running), 32'd0);
        check("reset_b.scnt",    32'(b_scnt),    32'd0);

        // Idle: mismatching samples without start are ignored.
        for (int i = 0; i < 10; i++) begin
            drive_a(1'b0, 1'b1, 4'h6, 4'h9);
            tick();
        end
        check_a("idle", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 4'h0);

        for (int i = 0; i < 14; i++) begin
            drive_a(vecs[i].st, vecs[i].v, vecs[i].r, vecs[i].d);
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].run, vecs[i].done, vecs[i].mism,
                    vecs[i].scnt, vecs[i].ecnt, vecs[i].fvld, vecs[i].fidx, vecs[i].mask);
        end

        // Errors at 7, 20, 21 over a full 100-sample run.
        drive_a(1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        for (int i = 0; i < 100; i++) begin
            if (i == 7 || i == 20 || i == 21) drive_a(1'b0, 1'b1, 4'h2, 4'h3);
            else                              drive_a(1'b0, 1'b1, 4'h2, 4'h2);
            tick();
            if (i == 98) check_a("err_run99", 1'b1, 1'b0, 1'b0, 99, 3, 1'b1, 7, 4'h1);
        end
        check_a("err_done", 1'b0, 1'b1, 1'b0, 100, 3, 1'b1, 7, 4'h1);
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, 1'b1, 4'h5, 4'hA);
            tick();
        end
        check_a("err_frozen", 1'b0, 1'b1, 1'b0, 100, 3, 1'b1, 7, 4'h1);

        // Clean run from DONE.
        drive_a(1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        check_a("clean_start", 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 4'h0);
        for (int i = 0; i < 100; i++) begin
            drive_a(1'b0, 1'b1, 4'(i), 4'(i));
            tick();
        end
        check_a("clean_done", 1'b0, 1'b1, 1'b0, 100, 0, 1'b0, 0, 4'h0);

        // Gaps: valid every other cycle.
        drive_a(1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive_a(1'b0, (i % 2) == 0, 4'h1, 4'h1);
            tick();
        end
        check_a("gaps", 1'b1, 1'b0, 1'b0, 8, 0, 1'b0, 0, 4'h0);

        // Reset mid-run after 50 samples with 5 errors.
        drive_a(1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        for (int i = 0; i < 50; i++) begin
            if ((i % 10) == 3) drive_a(1'b0, 1'b1, 4'h0, 4'h4);
            else               drive_a(1'b0, 1'b1, 4'h0, 4'h0);
            tick();
        end
        check_a("pre_reset", 1'b1, 1'b0, 1'b0, 50, 5, 1'b1, 3, 4'h4);
        drive_a(1'b0, 1'b0, 4'h0, 4'h0);
        #2 areset_n = 1'b0;
        #1;
        check_a("async_reset", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 4'h0);
        @(posedge clk);
        #3 areset_n = 1'b1;
        drive_a(1'b1, 1'b0, 4'h0, 4'h0);
        tick();
        drive_a(1'b0, 1'b1, 4'h3, 4'h3);
        tick();
        check_a("post_reset", 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 0, 4'h0);

        // Saturation on the CW=4 unbounded instance.
        ifb.start = 1'b1; ifb.sample_valid = 1'b0;
        tick();
        ifb.start = 1'b0; ifb.sample_valid = 1'b1; ifb.f_ref = 1'b1; ifb.f_dut = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) check("sat14.scnt", 32'(b_scnt), 32'd14);
        end
        ifb.sample_valid = 1'b0;
        check("sat.scnt",    32'(b_scnt),    32'd15);
        check("sat.ecnt",    32'(b_ecnt),    32'd15);
        check("sat.running", 32'(b_running), 32'd1);
        check("sat.done",    32'(b_done),    32'd0);
        check("sat.fvld",    32'(b_fvld),    32'd1);
        check("sat.fidx",    32'(b_fidx),    32'd0);
        check("sat.mism",    32'(b_mism),    32'd1);
        check("sat.mask",    32'(b_mask),    MASK_EN ? 32'd1 : 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
